multi_player_mover: RTL and testbench
=====================================

Name: multi_player_mover

Overview:
- Parametrised successor to the single-centre key controller. Moves NPLAYERS independent (x,y) positions, each driven by its own 4-key active-low pad.
- Positions change only during vertical blanking, between EOF and the next SOF, so values are stable while a frame is drawn.
- Adds configurable step size, frame-rate divider, per-axis clamping, per-player move pulses and a sequential update FSM.
- Feeds the sprite/display renderer.

Parameters:
- NPLAYERS, 2: number of player channels (1..8).
- W, 11: position width, unsigned.
- X_MIN, 0: lowest legal x.
- X_MAX, 799: highest legal x.
- Y_MIN, 0: lowest legal y.
- Y_MAX, 599: highest legal y.
- STEP, 1: pixels moved per update (1..15).
- FRAME_DIV, 1: update once every FRAME_DIV blanking periods (1..255).
- INIT_X, 400: reset x of player 0.
- INIT_Y, 300: reset y of every player.
- INIT_DX, 64: x offset between consecutive players at reset. Player i resets to x = INIT_X + i*INIT_DX, which must lie within [X_MIN, X_MAX].

Ports:
- clk, in, 1: system clock.
- reset_n, in, 1: asynchronous, active-low reset.
- SOF, in, 1: start-of-frame pulse, 1 cycle.
- EOF, in, 1: end-of-frame pulse, 1 cycle.
- enable, in, 1: 0 freezes all movement; frames are still counted.
- key, in, 4*NPLAYERS: player i uses key[4i+3:4i], active low. Bit0 = +x (right), bit1 = +y (down), bit2 = -y (up), bit3 = -x (left).
- pos_x, out, W*NPLAYERS: player i x at [W*i+W-1:W*i].
- pos_y, out, W*NPLAYERS: player i y, packed the same way.
- moved, out, NPLAYERS: 1-cycle pulse when player i's position changed.
- busy, out, 1: high while the FSM is in state UPD.

Behaviour:
- Reset (async, reset_n=0):
  - pos_x[i] = INIT_X + i*INIT_DX; pos_y[i] = INIT_Y.
  - moved = 0, busy = 0, FSM = DISP, frame counter = 0, key snapshot = all 1s.
- Frame lock: SOF has priority over EOF when both arrive in the same cycle. The EOF is then ignored and the FSM stays in or enters DISP.
- FSM states:
  - DISP: waiting for frame end. EOF moves to CNT.
  - CNT:
    - Frame counter increments.
    - If (counter+1)==FRAME_DIV and enable=1: counter clears, all keys are snapshotted into a register, idx=0, go to UPD.
    - If (counter+1)==FRAME_DIV and enable=0: counter clears, go to IDLE.
    - Otherwise go to IDLE.
  - UPD:
    - Processes player idx in 1 cycle, then idx++.
    - After idx==NPLAYERS-1, go to IDLE. A full update takes exactly NPLAYERS cycles.
  - IDLE: waiting in blanking. SOF moves to DISP.
  - SOF in any state forces DISP. An SOF during UPD aborts it: players not yet processed keep their positions for this frame, and busy drops the next cycle.
- Per-player update, using snapshot k (active low):
  - Move is accepted only if exactly one key is pressed: k ∈ {1110, 1101, 1011, 0111}.
  - Any other pattern (none pressed or multiple pressed) means no move.
- Clamping (no wrap-around):
  - +x: pos_x = min(pos_x+STEP, X_MAX).
  - -x: pos_x = (pos_x < X_MIN+STEP) ? X_MIN : pos_x-STEP.
  - y axis behaves the same using Y_MIN/Y_MAX.
  - Arithmetic is done at W+1 bits to avoid overflow.
- moved[i]:
  - Pulses in the cycle after player i's register is written.
  - Pulses only if the new value differs from the old one, so a move at a limit produces no pulse.
- Keys are sampled only at snapshot time. Key changes during UPD have no effect.
- pos_x/pos_y are registered outputs. They never change while the FSM is in DISP.

Optional Feature:
- Macro DIAGONAL_MOVE_EN.
- Defined:
  - Each axis is decoded independently: x from bits 0/3, y from bits 1/2.
  - Opposing keys on the same axis cancel on that axis only.
  - 1100 moves +x and +y in the same update.
- Undefined: single-key rule as specified above.

Test Plan:
- Reset release, NPLAYERS=2 -> pos_x = {464, 400} (player1, player0); pos_y = {300, 300}; moved = 0; busy = 0.
- Player0 key=1110, STEP=1, one EOF...SOF period -> player0 x 400→401; moved[0] pulses once; busy high exactly 2 cycles; player1 unchanged.
- Player0 at x=798, STEP=4, key=1110 -> x=799, moved pulse. Next frame -> x stays 799, no moved pulse.
- Player0 at x=2, key=0111, STEP=4 -> x=0.
- FRAME_DIV=3, key held at 1101 for 6 frames -> y increments exactly twice, after the 3rd and 6th EOF.
- key=1100 -> no move without the macro; x+1 and y+1 with DIAGONAL_MOVE_EN.
- SOF issued 1 cycle after entering UPD, NPLAYERS=4 -> only player0 moves, busy falls.
- EOF and SOF in the same cycle -> no update occurs.
- reset_n asserted mid-UPD -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/multi_player_mover.sv
// Moves NPLAYERS (x,y) positions from active-low 4-key pads, updating only during vertical blanking.
// Optional build macro DIAGONAL_MOVE_EN decodes each axis independently (diagonal moves allowed).
module multi_player_mover #(
    parameter int unsigned NPLAYERS  = 2,
    parameter int unsigned W         = 11,
    parameter int unsigned X_MIN     = 0,
    parameter int unsigned X_MAX     = 799,
    parameter int unsigned Y_MIN     = 0,
    parameter int unsigned Y_MAX     = 599,
    parameter int unsigned STEP      = 1,
    parameter int unsigned FRAME_DIV = 1,
    parameter int unsigned INIT_X    = 400,
    parameter int unsigned INIT_Y    = 300,
    parameter int unsigned INIT_DX   = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  SOF,
    input  logic                  EOF,
    input  logic                  enable,
    input  logic [4*NPLAYERS-1:0] key,
    output logic [W*NPLAYERS-1:0] pos_x,
    output logic [W*NPLAYERS-1:0] pos_y,
    output logic [NPLAYERS-1:0]   moved,
    output logic                  busy
);

    localparam int unsigned IW = (NPLAYERS > 1) ? $clog2(NPLAYERS) : 1;
    localparam int unsigned WE = W + 1;

    localparam logic [1:0] StDisp = 2'd0;
    localparam logic [1:0] StCnt  = 2'd1;
    localparam logic [1:0] StUpd  = 2'd2;
    localparam logic [1:0] StIdle = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [7:0]    cnt_q, cnt_d, cnt_inc;
    logic [IW-1:0] idx_q, idx_d;
    logic          take_snap;
    logic          do_write;
    logic [3:0]    snap_q [NPLAYERS];
    logic [W-1:0]  x_q    [NPLAYERS];
    logic [W-1:0]  y_q    [NPLAYERS];
    logic [NPLAYERS-1:0] moved_q;

    logic [3:0]   k;
    logic         right, left, down, up;
    logic [W-1:0] cur_x, cur_y, new_x, new_y;
    logic [WE-1:0] sum_x, sum_y;

    // SOF overrides everything, so a coincident EOF is dropped and an update in flight is aborted.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        take_snap = 1'b0;
        cnt_inc   = cnt_q + 8'd1;
        if (SOF) begin
            state_d = StDisp;
        end else begin
            case (state_q)
                StDisp: if (EOF) state_d = StCnt;
                StCnt: begin
                    if (cnt_inc == 8'(FRAME_DIV)) begin
                        cnt_d = 8'd0;
                        if (enable) begin
                            take_snap = 1'b1;
                            idx_d     = '0;
                            state_d   = StUpd;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        cnt_d   = cnt_inc;
                        state_d = StIdle;
                    end
                end
                StUpd: begin
                    if (idx_q == IW'(NPLAYERS - 1)) state_d = StIdle;
                    else                            idx_d   = idx_q + IW'(1);
                end
                default: state_d = state_q;
            endcase
        end
    end

    assign do_write = (state_q == StUpd) && !SOF;

    always_comb begin
        cur_x = x_q[idx_q];
        cur_y = y_q[idx_q];
        k     = snap_q[idx_q];
`ifdef DIAGONAL_MOVE_EN
        right = !k[0] &&  k[3];
        left  =  k[0] && !k[3];
        down  = !k[1] &&  k[2];
        up    =  k[1] && !k[2];
`else
        right = (k == 4'b1110);
        down  = (k == 4'b1101);
        up    = (k == 4'b1011);
        left  = (k == 4'b0111);
`endif
        // One extra bit so the upward clamp cannot wrap.
        sum_x = {1'b0, cur_x} + WE'(STEP);
        sum_y = {1'b0, cur_y} + WE'(STEP);
        new_x = cur_x;
        new_y = cur_y;
        if (right) begin
            new_x = (sum_x > WE'(X_MAX)) ? W'(X_MAX) : sum_x[W-1:0];
        end else if (left) begin
            new_x = ({1'b0, cur_x} < WE'(X_MIN + STEP)) ? W'(X_MIN) : cur_x - W'(STEP);
        end
        if (down) begin
            new_y = (sum_y > WE'(Y_MAX)) ? W'(Y_MAX) : sum_y[W-1:0];
        end else if (up) begin
            new_y = ({1'b0, cur_y} < WE'(Y_MIN + STEP)) ? W'(Y_MIN) : cur_y - W'(STEP);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StDisp;
            cnt_q   <= 8'd0;
            idx_q   <= '0;
            moved_q <= '0;
            for (int i = 0; i < NPLAYERS; i++) begin
                snap_q[i] <= 4'hF;
                x_q[i]    <= W'(INIT_X + i * INIT_DX);
                y_q[i]    <= W'(INIT_Y);
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            moved_q <= '0;
            if (take_snap) begin
                for (int i = 0; i < NPLAYERS; i++) snap_q[i] <= key[4*i +: 4];
            end
            if (do_write) begin
                x_q[idx_q]     <= new_x;
                y_q[idx_q]     <= new_y;
                moved_q[idx_q] <= (new_x != cur_x) || (new_y != cur_y);
            end
        end
    end

    for (genvar g = 0; g < NPLAYERS; g++) begin : g_out
        assign pos_x[W*g +: W] = x_q[g];
        assign pos_y[W*g +: W] = y_q[g];
    end

    assign moved = moved_q;
    assign busy  = (state_q == StUpd);

endmodule

// File: tb/tb_multi_player_mover.sv
// Randomized frame-level bench for multi_player_mover against a per-frame reference model.
// Compile with DIAGONAL_MOVE_EN defined to check the diagonal decode variant.
module tb_multi_player_mover;

    localparam int NP        = 4;
    localparam int W         = 11;
    localparam int X_MIN     = 16;
    localparam int X_MAX     = 620;
    localparam int Y_MIN     = 8;
    localparam int Y_MAX     = 330;
    localparam int STEP      = 7;
    localparam int FRAME_DIV = 2;
    localparam int INIT_X    = 400;
    localparam int INIT_Y    = 300;
    localparam int INIT_DX   = 64;
    localparam int KW        = 4 * NP;

    logic            clk = 1'b0;
    logic            reset_n, sof, eof, enable;
    logic [KW-1:0]   key;
    logic [W*NP-1:0] pos_x, pos_y;
    logic [NP-1:0]   moved;
    logic            busy;

    multi_player_mover #(
        .NPLAYERS (NP),        .W      (W),
        .X_MIN    (X_MIN),     .X_MAX  (X_MAX),
        .Y_MIN    (Y_MIN),     .Y_MAX  (Y_MAX),
        .STEP     (STEP),      .FRAME_DIV(FRAME_DIV),
        .INIT_X   (INIT_X),    .INIT_Y (INIT_Y),
        .INIT_DX  (INIT_DX)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .SOF    (sof),
        .EOF    (eof),
        .enable (enable),
        .key    (key),
        .pos_x  (pos_x),
        .pos_y  (pos_y),
        .moved  (moved),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: positions and frame counter.
    int mx [NP];
    int my [NP];
    int mcnt;

    // Running totals of moved pulses and busy cycles.
    int mov_tot [NP];
    int busy_tot = 0;
    initial for (int i = 0; i < NP; i++) mov_tot[i] = 0;

    always @(negedge clk) begin
        busy_tot += int'(busy);
        for (int i = 0; i < NP; i++) mov_tot[i] += int'(moved[i]);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            mx[i] = INIT_X + i * INIT_DX;
            my[i] = INIT_Y;
        end
        mcnt = 0;
    endtask

    task automatic model_move(input int i, input logic [3:0] k);
        int dx, dy, pressed;
        dx = int'(!k[0]) - int'(!k[3]);
        dy = int'(!k[1]) - int'(!k[2]);
        pressed = int'(!k[0]) + int'(!k[1]) + int'(!k[2]) + int'(!k[3]);
`ifndef DIAGONAL_MOVE_EN
        if (pressed != 1) begin
            dx = 0;
            dy = 0;
        end
`endif
        if (dx > 0) mx[i] = (mx[i] + STEP > X_MAX) ? X_MAX : mx[i] + STEP;
        if (dx < 0) mx[i] = (mx[i] < X_MIN + STEP) ? X_MIN : mx[i] - STEP;
        if (dy > 0) my[i] = (my[i] + STEP > Y_MAX) ? Y_MAX : my[i] + STEP;
        if (dy < 0) my[i] = (my[i] < Y_MIN + STEP) ? Y_MIN : my[i] - STEP;
    endtask

    task automatic check_pos(input string tag);
        for (int i = 0; i < NP; i++) begin
            check($sformatf("%s_x%0d", tag, i), 32'(pos_x[W*i +: W]), 32'(mx[i]));
            check($sformatf("%s_y%0d", tag, i), 32'(pos_y[W*i +: W]), 32'(my[i]));
        end
    endtask

    // One frame boundary: EOF, then SOF g cycles later (g=0 means same cycle as EOF).
    task automatic frame(input logic [KW-1:0] k, input logic en, input int g);
        int base_mov [NP];
        int base_busy, proc, bexp;
        int ox [NP];
        int oy [NP];
        @(posedge clk); #1;
        base_busy = busy_tot;
        for (int i = 0; i < NP; i++) base_mov[i] = mov_tot[i];
        @(negedge clk);
        key = k; enable = en; eof = 1'b1; sof = (g == 0);
        @(negedge clk);
        eof = 1'b0; sof = 1'b0;
        if (g >= 2) begin
            @(negedge clk);
            key = KW'($urandom);  // keys after the snapshot must be ignored
            repeat (g - 2) @(negedge clk);
            sof = 1'b1;
            @(negedge clk);
            sof = 1'b0;
        end
        repeat (NP + 3) @(negedge clk);
        @(posedge clk); #1;

        proc = 0;
        bexp = 0;
        if (g >= 2) begin
            mcnt++;
            if (mcnt == FRAME_DIV) begin
                mcnt = 0;
                if (en) begin
                    proc = (g - 2 < NP) ? g - 2 : NP;
                    bexp = (g - 1 < NP) ? g - 1 : NP;
                end
            end
        end
        for (int i = 0; i < NP; i++) begin
            ox[i] = mx[i];
            oy[i] = my[i];
        end
        for (int i = 0; i < proc; i++) model_move(i, k[4*i +: 4]);

        check("busy_cycles", 32'(busy_tot - base_busy), 32'(bexp));
        for (int i = 0; i < NP; i++)
            check($sformatf("moved%0d", i), 32'(mov_tot[i] - base_mov[i]),
                  32'((mx[i] != ox[i] || my[i] != oy[i]) ? 1 : 0));
        check_pos("pos");
    endtask

    function automatic logic [KW-1:0] all_keys(input logic [3:0] p0, input logic [3:0] p1,
                                               input logic [3:0] p2, input logic [3:0] p3);
        return {p3, p2, p1, p0};
    endfunction

    initial begin
        logic [3:0]    pats [7];
        logic [KW-1:0] kv;
        int            g;

        pats = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1111, 4'b1100, 4'b0000};
        reset_n = 1'b0; sof = 1'b0; eof = 1'b0; enable = 1'b0; key = '1;
        model_reset();
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_moved", 32'(moved), 32'd0);
        check_pos("rst");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check_pos("post_rst");

        // Single right press on player0; first frame only advances the divider.
        kv = all_keys(4'b1110, 4'b1111, 4'b1111, 4'b1111);
        frame(kv, 1'b1, NP + 3);
        frame(kv, 1'b1, NP + 3);

        // Drive every player into a different clamp and hold there.
        kv = all_keys(4'b0111, 4'b1011, 4'b1101, 4'b1110);
        for (int f = 0; f < 116; f++) frame(kv, 1'b1, NP + 3);

        // Combined keys, then away from the limits again.
        kv = all_keys(4'b1100, 4'b1100, 4'b0011, 4'b1111);
        for (int f = 0; f < 6; f++) frame(kv, 1'b1, NP + 3);

        // SOF aborting the update at different depths, and EOF+SOF together.
        kv = all_keys(4'b1110, 4'b1110, 4'b1110, 4'b1110);
        for (int f = 0; f < 2; f++) frame(kv, 1'b1, 3);
        for (int f = 0; f < 2; f++) frame(kv, 1'b1, 2);
        for (int f = 0; f < 2; f++) frame(kv, 1'b1, NP + 1);
        for (int f = 0; f < 3; f++) frame(kv, 1'b1, 0);
        for (int f = 0; f < 2; f++) frame(kv, 1'b0, NP + 3);

        for (int f = 0; f < 150; f++) begin
            for (int p = 0; p < NP; p++)
                kv[4*p +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom)
                                                             : pats[$urandom_range(0, 6)];
            g = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(2, NP + 4));
            frame(kv, ($urandom_range(0, 9) != 0), g);
        end

        // Reset in the middle of an update.
        kv = all_keys(4'b1101, 4'b1101, 4'b1101, 4'b1101);
        while (mcnt != FRAME_DIV - 1) frame('1, 1'b1, NP + 3);
        @(negedge clk);
        key = kv; enable = 1'b1; eof = 1'b1;
        @(negedge clk);
        eof = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_upd_busy", 32'(busy), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_moved", 32'(moved), 32'd0);
        check_pos("mid_rst");
        @(negedge clk);
        reset_n = 1'b1;
        kv = all_keys(4'b1011, 4'b1111, 4'b1111, 4'b0111);
        for (int f = 0; f < 4; f++) frame(kv, 1'b1, NP + 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
